branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Consumes the outputs of the global (GHR/PHT) predictor. Fetch enqueues each conditional-branch prediction together with the history snapshot used for the lookup.
- When execute resolves branches in program order, the block compares each outcome with its prediction. It drives PHT training, the committed global history, and misprediction recovery (flush plus restored GHR) back to fetch and the predictor.

Parameters:
DEPTH, 4, number of in-flight predicted branches tracked (power of two, 2..16)
GHR_BITS, 12, global history width; equals the PHT index width
ADDR_W, 32, instruction address width

Ports:
CLK  in  1  clock; all state changes on the rising edge
RESET  in  1  asynchronous, active-low reset
Pred_valid  in  1  fetch issued a prediction for a conditional branch this cycle
Pred_addr  in  ADDR_W  address of that branch
Pred_taken  in  1  predicted direction (1 = taken)
Pred_ghr  in  GHR_BITS  speculative history used as the PHT index, before the shift
Pred_ready  out  1  queue can accept an entry (count < DEPTH)
Resolve_valid  in  1  execute resolved the oldest outstanding branch
Resolve_addr  in  ADDR_W  address of the resolved branch
Resolve_taken  in  1  actual direction
Train_valid  out  1  one-cycle pulse: update PHT entry
Train_index  out  GHR_BITS  PHT index to update (stored snapshot)
Train_taken  out  1  direction to saturate toward
Mispredict  out  1  one-cycle pulse: flush fetch, restore history
Recover_ghr  out  GHR_BITS  history fetch/predictor must reload on Mispredict
Committed_ghr  out  GHR_BITS  architectural history, non-speculative
Count  out  $clog2(DEPTH+1)  current queue occupancy
Error  out  1  sticky protocol-violation flag

Behaviour:
- Reset (RESET low, asynchronous): queue empty, Count=0, Pred_ready=1, Committed_ghr=0. Train_valid, Train_index, Train_taken, Mispredict, Recover_ghr and Error all 0.
- The queue is an in-order circular FIFO of {addr, taken, ghr}. Pointers are $clog2(DEPTH) bits and wrap naturally. A separate occupancy counter distinguishes full from empty.
- Enqueue:
  - Occurs when Pred_valid and Pred_ready.
  - When full (Pred_ready=0), Pred_valid is ignored even if a dequeue happens the same cycle. The entry is lost and Error is not set. Fetch must stall on Pred_ready.
- Dequeue occurs when Resolve_valid and the queue is non-empty. All outputs are registered, so responses appear the cycle after Resolve_valid.
- Correct resolve (Resolve_addr == head.addr and Resolve_taken == head.taken):
  - Train_valid=1, Train_index=head.ghr, Train_taken=Resolve_taken.
  - Committed_ghr <= {Committed_ghr[GHR_BITS-2:0], Resolve_taken}.
- Mispredict (address matches, direction differs):
  - Same training and Committed_ghr update as a correct resolve.
  - Mispredict=1 and Recover_ghr = the new Committed_ghr value.
  - Every younger entry is squashed: queue empty, Count=0 next cycle.
  - A Pred_valid arriving in the same cycle is dropped, because it is younger than the mispredicted branch.
- Address mismatch with head:
  - Error <= 1 (sticky until reset).
  - Head is popped.
  - No training, no Mispredict, Committed_ghr unchanged.
- Resolve_valid on an empty queue: Error <= 1 and no other effect. A same-cycle enqueue still proceeds.
- Simultaneous enqueue and correct dequeue with the queue not full: both occur and Count is unchanged.
- Train_valid and Mispredict are single-cycle pulses. Train_index, Train_taken and Recover_ghr hold their last value when not pulsed.
- Reset asserted mid-operation discards all entries immediately and returns every output to its reset value.
- Count and Pred_ready are derived from registered occupancy only. Neither depends combinationally on same-cycle inputs.

Decomposition:
- Shared package bru_pkg:
  - GHR_BITS and ADDR_W defaults.
  - Packed struct bru_entry_t {addr, taken, ghr}.
  - Function ghr_shift(ghr, bit). The predictor uses the same function.
- One sub-module, bru_fifo:
  - Parameterised circular buffer with push, pop and clear.
  - Outputs full, empty, count, and head.
  - The top level holds the compare logic, history register and output registers.

Test Plan:
- Reset, then enqueue 0x400100/taken/ghr 0x0A5, then resolve 0x400100/taken -> next cycle Train_valid=1, Train_index=0x0A5, Train_taken=1, Mispredict=0, Committed_ghr=0x001, Count=0.
- Enqueue 4 branches (0x10, 0x14, 0x18, 0x1C, all predicted not-taken) -> Count=4, Pred_ready=0. A fifth Pred_valid is ignored. Resolving 0x10 not-taken -> Count=3, Pred_ready=1.
- With 3 entries queued, resolve head 0x20 as taken when predicted not-taken, plus a same-cycle Pred_valid 0x30 -> Mispredict=1, Recover_ghr = Committed_ghr shifted with 1, Count=0 next cycle, and 0x30 is not enqueued.
- Resolve_valid on an empty queue -> Error=1 (remains 1 across later correct resolves), Train_valid=0, Committed_ghr unchanged.
- Head 0x40 queued, Resolve_addr=0x44 -> Error=1, head popped, Train_valid=0, Mispredict=0.
- Fill 2 entries, assert RESET low mid-stream with no clock edge -> Count=0, Pred_ready=1 and all outputs 0 immediately. After release, a correct resolve of a new entry trains normally.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared types and helpers for the branch resolve unit.
// The global predictor uses ghr_shift too, so both sides shift history the same way.
package bru_pkg;

  localparam int GHR_BITS_D = 12;
  localparam int ADDR_W_D   = 32;

  typedef struct packed {
    logic [ADDR_W_D-1:0]   addr;
    logic                  taken;
    logic [GHR_BITS_D-1:0] ghr;
  } bru_entry_t;

  // Shift one outcome in at the LSB; callers truncate to their history width
  function automatic logic [31:0] ghr_shift(
    input logic [31:0] ghr,
    input logic        b
  );
    return {ghr[30:0], b};
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Prediction/resolution bus between fetch, execute and the resolve unit.
// master: fetch/execute side, slave: branch_resolve_unit.
interface branch_resolve_unit_if #(
  parameter int DEPTH    = 4,
  parameter int GHR_BITS = 12,
  parameter int ADDR_W   = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                Pred_valid;
  logic [ADDR_W-1:0]   Pred_addr;
  logic                Pred_taken;
  logic [GHR_BITS-1:0] Pred_ghr;
  logic                Pred_ready;
  logic                Resolve_valid;
  logic [ADDR_W-1:0]   Resolve_addr;
  logic                Resolve_taken;
  logic                Train_valid;
  logic [GHR_BITS-1:0] Train_index;
  logic                Train_taken;
  logic                Mispredict;
  logic [GHR_BITS-1:0] Recover_ghr;
  logic [GHR_BITS-1:0] Committed_ghr;
  logic [CW-1:0]       Count;
  logic                Error;

  modport master (
    output Pred_valid, Pred_addr, Pred_taken, Pred_ghr,
    output Resolve_valid, Resolve_addr, Resolve_taken,
    input  Pred_ready, Train_valid, Train_index, Train_taken,
    input  Mispredict, Recover_ghr, Committed_ghr, Count, Error
  );

  modport slave (
    input  Pred_valid, Pred_addr, Pred_taken, Pred_ghr,
    input  Resolve_valid, Resolve_addr, Resolve_taken,
    output Pred_ready, Train_valid, Train_index, Train_taken,
    output Mispredict, Recover_ghr, Committed_ghr, Count, Error
  );

endinterface

// File: rtl/bru_fifo.sv
// In-order circular buffer of predicted branches.
// clear wins over push/pop so a flush drops everything, including a same-cycle push.
module bru_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 45,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr;
  logic [PW-1:0] rd;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr  <= '0;
      rd  <= '0;
      cnt <= '0;
    end else if (clear) begin
      wr  <= '0;
      rd  <= '0;
      cnt <= '0;
    end else begin
      if (push) wr <= wr + PW'(1);
      if (pop)  rd <= rd + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr] <= din;
  end

  assign head  = mem[rd];
  assign count = cnt;
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/branch_resolve_unit.sv
// Checks in-order branch outcomes against queued GHR/PHT predictions and
// drives PHT training, committed history and misprediction recovery.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int GHR_BITS = GHR_BITS_D,
  parameter int ADDR_W   = ADDR_W_D
) (
  input  logic                  CLK,
  input  logic                  RESET,
  branch_resolve_unit_if.slave  bus
);

  localparam int EW = ADDR_W + 1 + GHR_BITS;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic                taken;
    logic [GHR_BITS-1:0] ghr;
  } entry_t;

  entry_t              din;
  entry_t              head;
  logic [EW-1:0]       head_raw;
  logic                full;
  logic                empty;
  logic [CW-1:0]       count;
  logic                deq;
  logic                addr_ok;
  logic                good;
  logic                mis;
  logic                push;
  logic                pop;
  logic [GHR_BITS-1:0] ghr_next;

  logic                train_valid;
  logic [GHR_BITS-1:0] train_index;
  logic                train_taken;
  logic                mispredict;
  logic [GHR_BITS-1:0] recover_ghr;
  logic [GHR_BITS-1:0] committed;
  logic                error;

  assign din.addr  = bus.Pred_addr;
  assign din.taken = bus.Pred_taken;
  assign din.ghr   = bus.Pred_ghr;
  assign head      = entry_t'(head_raw);

  assign deq      = bus.Resolve_valid && !empty;
  assign addr_ok  = (head.addr == bus.Resolve_addr);
  assign good     = deq && addr_ok;
  assign mis      = good && (head.taken != bus.Resolve_taken);
  // a push racing a mispredict is younger than it and must die with it
  assign push     = bus.Pred_valid && !full && !mis;
  assign pop      = deq && !mis;
  assign ghr_next =
    GHR_BITS'(ghr_shift(32'(committed), bus.Resolve_taken));

  bru_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET),
    .push  (push),
    .pop   (pop),
    .clear (mis),
    .din   (din),
    .head  (head_raw),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      train_valid <= 1'b0;
      train_index <= '0;
      train_taken <= 1'b0;
      mispredict  <= 1'b0;
      recover_ghr <= '0;
      committed   <= '0;
      error       <= 1'b0;
    end else begin
      train_valid <= good;
      mispredict  <= mis;
      if (good) begin
        train_index <= head.ghr;
        train_taken <= bus.Resolve_taken;
        committed   <= ghr_next;
      end
      if (mis) recover_ghr <= ghr_next;
      if ((bus.Resolve_valid && empty) || (deq && !addr_ok))
        error <= 1'b1;
    end
  end

  assign bus.Pred_ready    = !full;
  assign bus.Count         = count;
  assign bus.Train_valid   = train_valid;
  assign bus.Train_index   = train_index;
  assign bus.Train_taken   = train_taken;
  assign bus.Mispredict    = mispredict;
  assign bus.Recover_ghr   = recover_ghr;
  assign bus.Committed_ghr = committed;
  assign bus.Error         = error;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int GB    = 12;
  localparam int AW    = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic          taken;
    logic [GB-1:0] ghr;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  branch_resolve_unit_if #(
    .DEPTH(DEPTH), .GHR_BITS(GB), .ADDR_W(AW)
  ) bus ();

  branch_resolve_unit #(
    .DEPTH(DEPTH), .GHR_BITS(GB), .ADDR_W(AW)
  ) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass = 0;

  ent_t          mq[$];
  logic [GB-1:0] m_commit;
  logic          m_err;
  logic          m_tv;
  logic [GB-1:0] m_ti;
  logic          m_tt;
  logic          m_mis;
  logic [GB-1:0] m_rec;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    mq.delete();
    m_commit = '0;
    m_err = 1'b0;
    m_tv = 1'b0;
    m_ti = '0;
    m_tt = 1'b0;
    m_mis = 1'b0;
    m_rec = '0;
  endtask

  task automatic compare_all();
    check("count", 64'(bus.Count), 64'(mq.size()));
    check("ready", 64'(bus.Pred_ready), 64'(mq.size() < DEPTH));
    check("train_valid", 64'(bus.Train_valid), 64'(m_tv));
    check("train_index", 64'(bus.Train_index), 64'(m_ti));
    check("train_taken", 64'(bus.Train_taken), 64'(m_tt));
    check("mispredict", 64'(bus.Mispredict), 64'(m_mis));
    check("recover_ghr", 64'(bus.Recover_ghr), 64'(m_rec));
    check("committed", 64'(bus.Committed_ghr), 64'(m_commit));
    check("error", 64'(bus.Error), 64'(m_err));
  endtask

  task automatic drive_idle();
    bus.Pred_valid = 1'b0;
    bus.Pred_addr = '0;
    bus.Pred_taken = 1'b0;
    bus.Pred_ghr = '0;
    bus.Resolve_valid = 1'b0;
    bus.Resolve_addr = '0;
    bus.Resolve_taken = 1'b0;
  endtask

  // One clock: drive inputs, advance model by the rules, compare after edge
  task automatic step(input logic pv, input logic [AW-1:0] pa,
                      input logic pt, input logic [GB-1:0] pg,
                      input logic rv, input logic [AW-1:0] ra,
                      input logic rt);
    bit   was_full;
    bit   flush;
    ent_t h;
    ent_t e;
    bus.Pred_valid = pv;
    bus.Pred_addr = pa;
    bus.Pred_taken = pt;
    bus.Pred_ghr = pg;
    bus.Resolve_valid = rv;
    bus.Resolve_addr = ra;
    bus.Resolve_taken = rt;
    was_full = (mq.size() == DEPTH);
    flush = 0;
    m_tv = 1'b0;
    m_mis = 1'b0;
    if (rv) begin
      if (mq.size() == 0) begin
        m_err = 1'b1;
      end else begin
        h = mq.pop_front();
        if (h.addr != ra) begin
          m_err = 1'b1;
        end else begin
          m_tv = 1'b1;
          m_ti = h.ghr;
          m_tt = rt;
          m_commit = {m_commit[GB-2:0], rt};
          if (h.taken != rt) begin
            m_mis = 1'b1;
            m_rec = m_commit;
            flush = 1;
            mq.delete();
          end
        end
      end
    end
    if (pv && !was_full && !flush) begin
      e.addr = pa;
      e.taken = pt;
      e.ghr = pg;
      mq.push_back(e);
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic enq(input logic [AW-1:0] a, input logic t,
                     input logic [GB-1:0] g);
    step(1'b1, a, t, g, 1'b0, '0, 1'b0);
  endtask

  task automatic res(input logic [AW-1:0] a, input logic t);
    step(1'b0, '0, 1'b0, '0, 1'b1, a, t);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  // Asynchronous reset away from any clock edge
  task automatic do_reset();
    drive_idle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [GB-1:0] exp_rec;
    logic [AW-1:0] ra;
    logic          rt;
    drive_idle();
    model_reset();
    #3;
    compare_all();
    check("rst_ready", 64'(bus.Pred_ready), 64'd1);
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic correct resolve
    enq(32'h0040_0100, 1'b1, 12'h0A5);
    res(32'h0040_0100, 1'b1);
    check("tp1_index", 64'(bus.Train_index), 64'h0A5);
    check("tp1_commit", 64'(bus.Committed_ghr), 64'h001);
    check("tp1_valid", 64'(bus.Train_valid), 64'd1);
    idle();
    check("tp1_pulse", 64'(bus.Train_valid), 64'd0);

    // fill, overflow ignored, drain one
    enq(32'h10, 1'b0, 12'h001);
    enq(32'h14, 1'b0, 12'h002);
    enq(32'h18, 1'b0, 12'h003);
    enq(32'h1C, 1'b0, 12'h004);
    check("tp2_full", 64'(bus.Pred_ready), 64'd0);
    enq(32'h99, 1'b1, 12'h0FF);
    check("tp2_cnt4", 64'(bus.Count), 64'd4);
    // full plus dequeue: the push is still ignored
    step(1'b1, 32'h98, 1'b0, 12'h0EE, 1'b1, 32'h10, 1'b0);
    check("tp2_cnt3", 64'(bus.Count), 64'd3);
    check("tp2_ready", 64'(bus.Pred_ready), 64'd1);

    // mispredict with a same-cycle younger push
    do_reset();
    enq(32'h20, 1'b0, 12'h010);
    enq(32'h24, 1'b0, 12'h011);
    enq(32'h28, 1'b0, 12'h012);
    exp_rec = {bus.Committed_ghr[GB-2:0], 1'b1};
    step(1'b1, 32'h30, 1'b0, 12'h013, 1'b1, 32'h20, 1'b1);
    check("tp3_mis", 64'(bus.Mispredict), 64'd1);
    check("tp3_rec", 64'(bus.Recover_ghr), 64'(exp_rec));
    check("tp3_cnt", 64'(bus.Count), 64'd0);
    idle();
    check("tp3_mis_pulse", 64'(bus.Mispredict), 64'd0);

    // resolve on empty, then sticky across a good resolve
    res(32'h50, 1'b0);
    check("tp4_err", 64'(bus.Error), 64'd1);
    check("tp4_tv", 64'(bus.Train_valid), 64'd0);
    enq(32'h54, 1'b1, 12'h020);
    step(1'b1, 32'h58, 1'b0, 12'h021, 1'b1, 32'h54, 1'b1);
    check("tp4_sticky", 64'(bus.Error), 64'd1);
    check("tp4_cnt", 64'(bus.Count), 64'd1);

    // address mismatch pops head
    do_reset();
    enq(32'h40, 1'b1, 12'h030);
    res(32'h44, 1'b1);
    check("tp5_err", 64'(bus.Error), 64'd1);
    check("tp5_cnt", 64'(bus.Count), 64'd0);
    check("tp5_commit", 64'(bus.Committed_ghr), 64'd0);

    // reset mid-stream, then normal training
    do_reset();
    enq(32'h60, 1'b1, 12'h040);
    enq(32'h64, 1'b0, 12'h041);
    do_reset();
    check("tp6_cnt", 64'(bus.Count), 64'd0);
    enq(32'h70, 1'b0, 12'h3C3);
    res(32'h70, 1'b0);
    check("tp6_index", 64'(bus.Train_index), 64'h3C3);
    check("tp6_commit", 64'(bus.Committed_ghr), 64'd0);

    // random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      ra = $urandom & 32'hFFFF_FFFC;
      rt = 1'($urandom);
      if (mq.size() != 0 && $urandom_range(0, 19) != 0) begin
        ra = mq[0].addr;
        if ($urandom_range(0, 9) < 8) rt = mq[0].taken;
      end
      step(1'($urandom_range(0, 2) != 0),
           $urandom & 32'hFFFF_FFFC,
           1'($urandom),
           GB'($urandom),
           (mq.size() != 0) ? 1'($urandom_range(0, 2) == 0)
                            : 1'($urandom_range(0, 29) == 0),
           ra, rt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
